// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding and port ids.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_mux2to1.sv
// Two-input word mux: sel=0 passes din1, sel=1 passes din2.
module mux2to1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] din1,
  input  logic [W-1:0] din2,
  input  logic         sel,
  output logic [W-1:0] dout
);

  assign dout = sel ? din2 : din1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between two requesters.
// Optional ARB_STATS_EN macro adds saturating per-port grant counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
`ifdef ARB_STATS_EN
  ,
  parameter int STAT_W      = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata,
  output logic              mux_sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] gnt_cnt0,
  output logic [STAT_W-1:0] gnt_cnt1
`endif
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic             last_grant;
  logic             pick;

  // Contention goes to the port that did not win last; otherwise the sole requester wins.
  assign pick = (req0 && req1) ? ~last_grant : req1;

  mux2to1 #(.W(DATA_W)) u_addr_mux (
    .din1 (addr0),
    .din2 (addr1),
    .sel  (mux_sel),
    .dout (mem_addr)
  );

  mux2to1 #(.W(DATA_W)) u_wdata_mux (
    .din1 (wdata0),
    .din2 (wdata1),
    .sel  (mux_sel),
    .dout (mem_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      last_grant <= PORT1;
      mux_sel    <= PORT0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      rdata      <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            mux_sel <= pick;
            gnt0    <= (pick == PORT0);
            gnt1    <= (pick == PORT1);
            we_q    <= pick ? we1 : we0;
            mem_en  <= 1'b1;
            mem_we  <= pick ? we1 : we0;
            cnt     <= CNT_W'(MEM_LATENCY - 1);
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            if (!we_q) rdata <= mem_rdata;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            ack0       <= (mux_sel == PORT0);
            ack1       <= (mux_sel == PORT1);
            last_grant <= mux_sel;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          mux_sel <= PORT0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (ack0 && (gnt_cnt0 != '1)) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (ack1 && (gnt_cnt1 != '1)) gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end
`endif

endmodule
